// File: rtl/deser_pkg.sv
// Shared types and constants for the bit_deserializer slice.
package deser_pkg;

  localparam int DESER_WIDTH_DEF = 8;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } ostate_t;

endpackage

// File: rtl/deser_bit_counter.sv
// Wrapping 0..FRAME-1 bit counter with enable and a last-bit flag.
module deser_bit_counter #(
  parameter int FRAME = 8,
  parameter int CW    = $clog2(FRAME)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  assign last = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel unpacker: shift stage plus output holding register.
// Optional even-parity frame bit enabled by defining BIT_DESERIALIZER_PARITY_EN.
module bit_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH_DEF,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_perr,
  output logic             busy
);

`ifdef BIT_DESERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);

  logic [CW-1:0]    cnt_p0;
  logic             last_p0;
  logic             take_p0;
  logic             complete_p0;
  logic             shift_en_p0;
  logic [WIDTH-1:0] shreg_p0;
  logic [WIDTH-1:0] shifted_p0;
  logic [WIDTH-1:0] word_p0;
  ostate_t          state_p1;

  deser_bit_counter #(
    .FRAME (FRAME),
    .CW    (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (take_p0),
    .cnt  (cnt_p0),
    .last (last_p0)
  );

  // The final frame bit is refused only while a stalled word still occupies the output.
  assign sin_ready   = !rst && !(last_p0 && dout_valid && !dout_ready);
  assign take_p0     = sin_valid && sin_ready;
  assign complete_p0 = take_p0 && last_p0;
  assign busy        = (cnt_p0 != '0);
  assign dout_valid  = (state_p1 == ST_FULL);

  always_comb begin
    shifted_p0 = shreg_p0;
    if (MSB_FIRST != 0) begin
      shifted_p0 = {shreg_p0[WIDTH-2:0], sin};
    end else begin
      shifted_p0 = {sin, shreg_p0[WIDTH-1:1]};
    end
  end

`ifdef BIT_DESERIALIZER_PARITY_EN
  // Parity bit closes the frame and never enters the data shift register.
  assign shift_en_p0 = take_p0 && !last_p0;
  assign word_p0     = shreg_p0;
`else
  assign shift_en_p0 = take_p0;
  assign word_p0     = shifted_p0;
`endif

  // Stage p0: shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_p0 <= '0;
    end else if (shift_en_p0) begin
      shreg_p0 <= shifted_p0;
    end
  end

  // Stage p1: output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_EMPTY;
      dout     <= '0;
    end else if (complete_p0) begin
      state_p1 <= ST_FULL;
      dout     <= word_p0;
    end else if (dout_valid && dout_ready) begin
      state_p1 <= ST_EMPTY;
    end
  end

`ifdef BIT_DESERIALIZER_PARITY_EN
  logic perr_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_p1 <= 1'b0;
    end else if (complete_p0) begin
      perr_p1 <= (^shreg_p0) ^ sin;
    end
  end

  assign dout_perr = perr_p1;
`else
  assign dout_perr = 1'b0;
`endif

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer; LSB-first and MSB-first instances share stimulus.
module tb_bit_deserializer;

`ifdef BIT_DESERIALIZER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       dout_ready;

  logic       sin_ready_a, dout_valid_a, dout_perr_a, busy_a;
  logic [7:0] dout_a;
  logic       sin_ready_b, dout_valid_b, dout_perr_b, busy_b;
  logic [7:0] dout_b;

  int checks = 0;
  int errors = 0;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready_a),
    .dout       (dout_a),
    .dout_valid (dout_valid_a),
    .dout_ready (dout_ready),
    .dout_perr  (dout_perr_a),
    .busy       (busy_a)
  );

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready_b),
    .dout       (dout_b),
    .dout_valid (dout_valid_b),
    .dout_ready (dout_ready),
    .dout_perr  (dout_perr_b),
    .busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input logic [7:0] w, input logic par, input int i);
    return (i < 8) ? w[i] : par;
  endfunction

  // Drives frame bits lo..hi of word w back to back; sin_valid left high.
  task automatic send_range(input logic [7:0] w, input logic par, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sin       = fbit(w, par, i);
      sin_valid = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst        = 1'b1;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    dout_ready = 1'b0;
    #1;
    check("rst_sin_ready", sin_ready_a, 1'b0);
    tick();
    tick();
    check("rst_dout", dout_a, 8'h00);
    check("rst_dout_valid", dout_valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_perr", dout_perr_a, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_sin_ready", sin_ready_a, 1'b1);

    // Bits 1,0,1,1,0,0,1,0 back to back, consumer always ready
    dout_ready = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      sin       = fbit(8'h4D, ^8'h4D, i);
      sin_valid = 1'b1;
      tick();
      if (i == FRAME - 2) check("t1_valid_early", dout_valid_a, 1'b0);
    end
    check("t1_dout_lsb_first", dout_a, 8'h4D);
    check("t1_dout_msb_first", dout_b, 8'hB2);
    check("t1_valid", dout_valid_a, 1'b1);
    check("t1_valid_b", dout_valid_b, 1'b1);
    check("t1_busy", busy_a, 1'b0);
    check("t1_perr", dout_perr_a, 1'b0);
    sin_valid = 1'b0;
    tick();
    check("t1_valid_one_cycle", dout_valid_a, 1'b0);

    // Backpressure: two words streamed with the consumer stalled
    dout_ready = 1'b0;
    send_range(8'h4D, ^8'h4D, 0, FRAME - 1);
    check("t3_w1_valid", dout_valid_a, 1'b1);
    check("t3_w1_dout", dout_a, 8'h4D);
    for (int i = 0; i < FRAME - 1; i++) begin
      sin       = fbit(8'hA7, ^8'hA7, i);
      sin_valid = 1'b1;
      #1;
      check($sformatf("t3_ready_bit%0d", i), sin_ready_a, 1'b1);
      tick();
    end
    check("t3_w1_stable", dout_a, 8'h4D);
    sin       = fbit(8'hA7, ^8'hA7, FRAME - 1);
    sin_valid = 1'b1;
    #1;
    check("t3_last_refused", sin_ready_a, 1'b0);
    tick();
    tick();
    check("t3_hold_dout", dout_a, 8'h4D);
    check("t3_hold_valid", dout_valid_a, 1'b1);
    check("t3_hold_busy", busy_a, 1'b1);
    check("t3_hold_ready", sin_ready_a, 1'b0);
    dout_ready = 1'b1;
    #1;
    check("t3_release_ready", sin_ready_a, 1'b1);
    check("t3_w1_presented", dout_a, 8'h4D);
    tick();
    check("t3_w2_dout", dout_a, 8'hA7);
    check("t3_w2_valid", dout_valid_a, 1'b1);
    check("t3_w2_busy", busy_a, 1'b0);
    sin_valid = 1'b0;
    tick();
    check("t3_drained", dout_valid_a, 1'b0);

    // Drain word 1 in the same cycle the last bit of word 2 arrives
    dout_ready = 1'b0;
    send_range(8'h3C, ^8'h3C, 0, FRAME - 1);
    send_range(8'h5A, ^8'h5A, 0, FRAME - 2);
    check("t4_w1_dout", dout_a, 8'h3C);
    check("t4_w1_valid", dout_valid_a, 1'b1);
    sin        = fbit(8'h5A, ^8'h5A, FRAME - 1);
    sin_valid  = 1'b1;
    dout_ready = 1'b1;
    tick();
    check("t4_w2_dout", dout_a, 8'h5A);
    check("t4_w2_valid", dout_valid_a, 1'b1);
    sin_valid = 1'b0;
    tick();
    check("t4_drained", dout_valid_a, 1'b0);

    // Reset mid-word, then a full 0xFF word with a gap inside it
    send_range(8'h15, 1'b0, 0, 4);
    sin_valid = 1'b0;
    check("t5_partial_busy", busy_a, 1'b1);
    rst = 1'b1;
    tick();
    check("t5_rst_busy", busy_a, 1'b0);
    check("t5_rst_valid", dout_valid_a, 1'b0);
    rst = 1'b0;
    send_range(8'hFF, ^8'hFF, 0, 3);
    sin_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t5_gap_busy", busy_a, 1'b1);
    check("t5_gap_valid", dout_valid_a, 1'b0);
    send_range(8'hFF, ^8'hFF, 4, FRAME - 1);
    sin_valid = 1'b0;
    check("t5_dout", dout_a, 8'hFF);
    check("t5_dout_b", dout_b, 8'hFF);
    check("t5_valid", dout_valid_a, 1'b1);
    check("t5_perr", dout_perr_a, 1'b0);
    tick();
    check("t5_drained", dout_valid_a, 1'b0);

`ifdef BIT_DESERIALIZER_PARITY_EN
    // Parity frames: correct even parity, then a flipped parity bit
    send_range(8'h4D, 1'b0, 0, FRAME - 1);
    sin_valid = 1'b0;
    check("par_ok_dout", dout_a, 8'h4D);
    check("par_ok_perr", dout_perr_a, 1'b0);
    tick();
    send_range(8'h4D, 1'b1, 0, FRAME - 1);
    sin_valid = 1'b0;
    check("par_bad_dout", dout_a, 8'h4D);
    check("par_bad_perr", dout_perr_a, 1'b1);
    check("par_bad_perr_b", dout_perr_b, 1'b1);
    check("par_bad_dout_b", dout_b, 8'hB2);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
